// File: rtl/aes256_pkg.sv
// aes256_arb shared types: FSM encoding, widths, requester count.
// Imported by the arbiter, its round-robin picker and the bus interface.
package aes256_pkg;

  localparam int KEY_W = 256;
  localparam int BLK_W = 128;
  localparam int NREQ  = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/aes256_arb_if.sv
// aes256_arb bus: two requesters, response port, AES core link.
// slave = arbiter side, master = requesters plus core side.
interface aes256_arb_if;
  import aes256_pkg::*;

  logic             req0_valid;
  logic             req1_valid;
  logic [KEY_W-1:0] req0_key;
  logic [KEY_W-1:0] req1_key;
  logic [BLK_W-1:0] req0_data;
  logic [BLK_W-1:0] req1_data;
  logic             req0_ack;
  logic             req1_ack;
  logic             rsp_valid;
  logic             rsp_id;
  logic [BLK_W-1:0] rsp_data;
  logic             rsp_err;
  logic             core_start;
  logic [KEY_W-1:0] core_key;
  logic [BLK_W-1:0] core_data;
  logic [BLK_W-1:0] core_out;
  logic             core_ready;

  modport slave (
    input  req0_valid, req1_valid,
    input  req0_key, req1_key,
    input  req0_data, req1_data,
    output req0_ack, req1_ack,
    output rsp_valid, rsp_id,
    output rsp_data, rsp_err,
    output core_start, core_key,
    output core_data,
    input  core_out, core_ready
  );

  modport master (
    output req0_valid, req1_valid,
    output req0_key, req1_key,
    output req0_data, req1_data,
    input  req0_ack, req1_ack,
    input  rsp_valid, rsp_id,
    input  rsp_data, rsp_err,
    input  core_start, core_key,
    input  core_data,
    output core_out, core_ready
  );

endinterface

// File: rtl/aes256_rr_arb.sv
// 2-way round-robin pick for aes256_arb.
// A lone requester wins; on a tie the one not served last wins.
module aes256_rr_arb (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_vld,
  output logic       o_id
);

  assign o_vld = |i_req;

  // tie -> the other one; otherwise whichever is pending
  assign o_id = (&i_req) ? ~i_last : i_req[1];

endmodule

// File: rtl/aes256_arb.sv
// Two-requester front end for one aes256_enc core.
// Optional core timeout enabled by macro AES_ARB_TIMEOUT_EN.
module aes256_arb
  import aes256_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input logic        clk,
  input logic        reset_n,
  aes256_arb_if.slave bus
);

  state_t           r_state;
  logic             r_last;
  logic             r_id;
  logic             r_wait1;
  logic             r_ack0;
  logic             r_ack1;
  logic             r_start;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [BLK_W-1:0] r_rsp_data;
  logic [KEY_W-1:0] r_key;
  logic [BLK_W-1:0] r_data;
  logic             w_gnt_vld;
  logic             w_gnt_id;

`ifdef AES_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST =
    CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] r_cnt;
  logic          r_rsp_err;
  assign bus.rsp_err = r_rsp_err;
`else
  logic w_unused_to;
  assign w_unused_to = (TIMEOUT_CYCLES != 0);
  assign bus.rsp_err = 1'b0;
`endif

  aes256_rr_arb u_rr (
    .i_req  ({bus.req1_valid, bus.req0_valid}),
    .i_last (r_last),
    .o_vld  (w_gnt_vld),
    .o_id   (w_gnt_id)
  );

  assign bus.req0_ack   = r_ack0;
  assign bus.req1_ack   = r_ack1;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.core_start = r_start;
  assign bus.core_key   = r_key;
  assign bus.core_data  = r_data;

  // job sequencer with registered pulses and capture registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_id        <= 1'b0;
      r_wait1     <= 1'b0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_start     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= '0;
      r_key       <= '0;
      r_data      <= '0;
`ifdef AES_ARB_TIMEOUT_EN
      r_cnt       <= '0;
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_start     <= 1'b0;
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_gnt_vld) begin
            r_state <= GRANT;
            r_id    <= w_gnt_id;
            r_ack0  <= ~w_gnt_id;
            r_ack1  <= w_gnt_id;
            r_key   <= w_gnt_id ? bus.req1_key
                                : bus.req0_key;
            r_data  <= w_gnt_id ? bus.req1_data
                                : bus.req0_data;
          end
        end
        GRANT: begin
          r_state <= START;
          r_start <= 1'b1;
        end
        START: begin
          r_state <= WAIT;
          r_wait1 <= 1'b1;
`ifdef AES_ARB_TIMEOUT_EN
          r_cnt   <= '0;
`endif
        end
        WAIT: begin
          r_wait1 <= 1'b0;
          if (!r_wait1 && bus.core_ready) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_data  <= bus.core_out;
`ifdef AES_ARB_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
          end else if (r_cnt == TO_LAST) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
`endif
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_last  <= r_id;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
